// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the core and the loader, and sequences the core's run state
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          res,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_adr,
    input  logic [DW-1:0] core_wd,
    output logic [DW-1:0] core_rd,
    output logic          core_ack,
    output logic          core_stall,
    output logic          core_run,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_adr,
    input  logic [DW-1:0] ldr_wd,
    output logic [DW-1:0] ldr_rd,
    output logic          ldr_ack,
    input  logic          ldr_done,
    input  logic          halt_req,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic [1:0]    arb_state
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT_PEND = 2'd2, HALTED = 2'd3} state_e;
    localparam logic [3:0] MAX = 4'(MAX_STREAK);
    state_e     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       core_run_q, core_run_d;
    logic       gnt_c, gnt_l;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= BOOT;
            streak_q   <= '0;
            core_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            core_run_q <= core_run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:      state_d = ldr_done ? RUN : BOOT;
            RUN:       state_d = halt_req ? HALT_PEND : RUN;
            HALT_PEND: state_d = !halt_req ? RUN : !core_req ? HALTED : HALT_PEND;
            default:   state_d = !halt_req ? RUN : HALTED;
        endcase
    end

    // In HALT_PEND the core has absolute priority; BOOT and HALTED serve only the loader.
    always_comb begin
        gnt_c      = core_req & ((state_q == RUN & (~ldr_req | streak_q == MAX)) | state_q == HALT_PEND);
        gnt_l      = ldr_req & ~gnt_c & (state_q != HALT_PEND | ~core_req);
        streak_d   = (state_q != RUN | ~core_req | gnt_c) ? 4'd0 :
                     (gnt_l & streak_q != MAX) ? streak_q + 4'd1 : streak_q;
        core_run_d = state_d == RUN | state_d == HALT_PEND;
        mem_a      = gnt_c ? core_adr : gnt_l ? ldr_adr : '0;
        mem_wd     = gnt_c ? core_wd : gnt_l ? ldr_wd : '0;
        mem_we     = ~res & ((gnt_c & core_we) | (gnt_l & ldr_we));
        core_ack   = gnt_c;
        ldr_ack    = gnt_l;
        core_stall = core_req & ~gnt_c;
        core_rd    = mem_rd;
        ldr_rd     = mem_rd;
        core_run   = core_run_q;
        arb_state  = state_q;
    end
endmodule
